totient_sequencer: RTL and testbench
====================================

// Module: totient_sequencer
// PURPOSE
//  Steps an index n through 1..N_MAX and computes Euler's totient phi(n) on the fly.
//  For each k in 1..n it runs a subtractive-Euclid GCD and counts the k with gcd(n,k)=1.
//  Adds run-time up/down direction, selectable wrap/hold at the ends, and a ready/busy handshake.
//  Drives a hex 7-segment display (ABCDEFG) plus full-width phi and n; sits between the board clock/button logic and the display.
// PARAMETERS
//  N_MAX          16   last index; legal range 2..255
//  NW             $clog2(N_MAX+1)  width of n_out and phi_out (derived, not overridden)
//  SEG_ACTIVE_LOW 0    1 = invert A..G for common-anode displays
// PORTS
//  clk_0    in   1   system clock, rising edge
//  R        in   1   asynchronous active-low reset
//  step     in   1   request to advance to the next index; sampled only while ready=1
//  dir      in   1   0 = up (n+1), 1 = down (n-1); sampled with an accepted step
//  wrap     in   1   1 = wrap at the ends, 0 = hold at the ends; sampled with an accepted step
//  ready    out  1   1 = phi_out is valid and step is accepted
//  busy     out  1   ~ready
//  done     out  1   1 = holding at an end (wrap=0 and step would leave 1..N_MAX)
//  n_out    out  NW  current index
//  phi_out  out  NW  phi(n_out); valid only while ready=1
//  ovf      out  1   phi_out > 15, so the display shows only the low nibble
//  A,B,C,D,E,F,G out 1 each  hex segments of phi_out[3:0], driven from a registered value
// BEHAVIOUR
//  Reset (R=0, async, overrides every other input):
//   - state=SHOW, n_out=1, phi_out=1, ready=1, done=0, ovf=0
//   - ABCDEFG=0110000 (digit "1"; inverted when SEG_ACTIVE_LOW=1)
//   - an in-flight computation is discarded immediately
//  FSM states: SHOW -> NEXT -> GCD -> ACC -> (GCD | SHOW).
//   SHOW: ready=1. On step=1, compute the target index:
//    - up from N_MAX: target=1 if wrap=1; otherwise stay in SHOW, set done=1, leave outputs unchanged.
//    - down from 1: target=N_MAX if wrap=1; otherwise stay in SHOW, set done=1, leave outputs unchanged.
//    - otherwise the target is n_out+1 or n_out-1.
//    - done clears on any accepted move.
//   NEXT: load n_out=target, cnt=0, k=1; ready=0; phi_out holds its old value (flagged invalid).
//   GCD: start gcd_engine(n,k) and wait for gdone.
//   ACC: if g==1, cnt++. If k==n, then phi_out<=cnt (+1 if this k counted), go to SHOW; else k++ and go to GCD.
//  Step pulses while ready=0 are ignored, not queued. dir and wrap change only take effect at acceptance.
//  phi(1)=1 falls out naturally (gcd(1,1)=1); no special case.
//  Latency from step acceptance to ready: variable, <= 2 + n*(n+3) cycles. The bench checks this bound.
//  The display and ovf update in the same edge that phi_out loads. They are frozen while busy.
//  All arithmetic is unsigned NW bits. cnt never exceeds n, so there is no overflow.
// STRUCTURE
//  totient_pkg:
//   - state enum
//   - SEG_HEX[0:15] constant table: ABCDEFG, active-high, 0..F
//   - seg_encode(nibble, active_low) function
//  gcd_engine: sub-module, parameter W.
//   - ports: clk_0, R, start, a, b -> g, gdone
//   - subtractive Euclid: if a>b then a-=b, else if b>a then b-=a, else done
//   - <= max(a,b) cycles; inputs a,b >= 1
//  top: FSM, index/counter registers, display register.
// TESTING
//  1 Release R, wrap=0, dir=0, 15 steps each after ready.
//    -> phi = 1,1,2,2,4,2,6,4,6,4,10,4,12,6,8,8; ABCDEFG for 10=1110111 (A), 12=1001110 (C).
//    -> a 16th step gives done=1, n_out=16 unchanged.
//  2 From n=16: dir=1, wrap=1, steps -> phi(15)=8, phi(14)=6, phi(13)=12.
//    Continue to n=1; the next step -> n_out=16, phi_out=8, done=0.
//  3 Assert step for 5 consecutive cycles starting at acceptance -> n_out advances by exactly 1; ready low until computed.
//  4 Pull R low mid-GCD at n=12 -> same cycle: n_out=1, phi_out=1, ready=1, ABCDEFG=0110000.
//    After release, the next step yields phi(2)=1.
//  5 N_MAX=32: n=31 -> phi_out=30, ovf=1, segments show E (1001111).
//    n=32 -> phi_out=16, ovf=1, segments show 0 (1111110).
//  6 Every step across N_MAX=16 and N_MAX=32 -> measured latency <= 2+n*(n+3).
//    SEG_ACTIVE_LOW=1 -> segments are the bitwise inverse.

Source files
------------

// File: rtl/totient_pkg.sv
// Shared types and display encoding for the totient sequencer.
// Segment bit order is {A,B,C,D,E,F,G}, MSB first.
package totient_pkg;

  typedef enum logic [1:0] {SHOW, NEXT, GCD, ACC} state_t;

  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble, input logic active_low);
    return active_low ? ~SEG_HEX[nibble] : SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/totient_if.sv
// Step handshake and result bus between the button logic and the totient sequencer.
interface totient_if #(parameter int N_MAX = 16);
  localparam int NW = $clog2(N_MAX + 1);

  logic          step;
  logic          dir;
  logic          wrap;
  logic          ready;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [NW-1:0] n_out;
  logic [NW-1:0] phi_out;

  modport master (output step, dir, wrap,
                  input  ready, busy, done, ovf, n_out, phi_out);
  modport slave  (input  step, dir, wrap,
                  output ready, busy, done, ovf, n_out, phi_out);
endinterface

// File: rtl/gcd_engine.sv
// Subtractive-Euclid GCD: one subtraction per cycle, gdone while both operands agree.
// start is honoured only while idle; operands must be >= 1.
module gcd_engine #(parameter int W = 8) (
  input  logic         clk_0,
  input  logic         R,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] g,
  output logic         gdone
);

  logic         run_reg;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;

  always_ff @(posedge clk_0 or negedge R) begin
    if (!R) begin
      run_reg <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
    end else if (!run_reg) begin
      if (start) begin
        run_reg <= 1'b1;
        a_reg   <= a;
        b_reg   <= b;
      end
    end else if (a_reg > b_reg) begin
      a_reg <= a_reg - b_reg;
    end else if (b_reg > a_reg) begin
      b_reg <= b_reg - a_reg;
    end else begin
      run_reg <= 1'b0;
    end
  end

  assign g     = a_reg;
  assign gdone = run_reg && (a_reg == b_reg);

endmodule

// File: rtl/totient_sequencer.sv
// Steps n through 1..N_MAX and recomputes phi(n) by counting k in 1..n with gcd(n,k)=1.
// The display and ovf are registered alongside phi_out and stay frozen while busy.
module totient_sequencer
  import totient_pkg::*;
#(
  parameter int N_MAX          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic     clk_0,
  input  logic     R,
  totient_if.slave bus,
  output logic     A,
  output logic     B,
  output logic     C,
  output logic     D,
  output logic     E,
  output logic     F,
  output logic     G
);

  localparam int            NW    = $clog2(N_MAX + 1);
  localparam logic [NW-1:0] N_TOP = NW'(N_MAX);
  localparam logic [NW-1:0] ONE   = NW'(1);

  state_t        state_reg, state_next;
  logic [NW-1:0] n_reg, k_reg, cnt_reg, phi_reg, target_reg;
  logic [NW-1:0] target_next, cnt_inc, g;
  logic [NW+3:0] cnt_wide;
  logic [6:0]    seg_reg;
  logic          done_reg, ovf_reg, coprime_reg;
  logic          at_top, at_bot, hold_end, accept, start, gdone, ready;

  gcd_engine #(.W(NW)) u_gcd (
    .clk_0 (clk_0),
    .R     (R),
    .start (start),
    .a     (n_reg),
    .b     (k_reg),
    .g     (g),
    .gdone (gdone)
  );

  always_comb begin
    at_top      = (n_reg == N_TOP);
    at_bot      = (n_reg == ONE);
    hold_end    = !bus.wrap && (bus.dir ? at_bot : at_top);
    accept      = (state_reg == SHOW) && bus.step && !hold_end;
    target_next = bus.dir ? (at_bot ? N_TOP : n_reg - ONE)
                          : (at_top ? ONE   : n_reg + ONE);
    cnt_inc     = cnt_reg + {{(NW-1){1'b0}}, coprime_reg};
    cnt_wide    = {4'b0000, cnt_inc};
  end

  always_ff @(posedge clk_0 or negedge R) begin
    if (!R) state_reg <= SHOW;
    else    state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SHOW:    if (accept) state_next = NEXT;
      NEXT:    state_next = GCD;
      GCD:     if (gdone) state_next = ACC;
      ACC:     state_next = (k_reg == n_reg) ? SHOW : GCD;
      default: state_next = SHOW;
    endcase
  end

  // The engine ignores start while running, so holding it through GCD issues exactly one job.
  always_comb begin
    ready = (state_reg == SHOW);
    start = (state_reg == GCD);
  end

  always_ff @(posedge clk_0 or negedge R) begin
    if (!R) begin
      n_reg       <= ONE;
      k_reg       <= ONE;
      cnt_reg     <= '0;
      phi_reg     <= ONE;
      target_reg  <= ONE;
      done_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      coprime_reg <= 1'b0;
      seg_reg     <= seg_encode(4'd1, SEG_ACTIVE_LOW);
    end else begin
      case (state_reg)
        SHOW: begin
          target_reg <= target_next;
          if (bus.step) done_reg <= hold_end;
        end
        NEXT: begin
          n_reg   <= target_reg;
          cnt_reg <= '0;
          k_reg   <= ONE;
        end
        GCD: if (gdone) coprime_reg <= (g == ONE);
        ACC: begin
          cnt_reg <= cnt_inc;
          if (k_reg == n_reg) begin
            phi_reg <= cnt_inc;
            seg_reg <= seg_encode(cnt_wide[3:0], SEG_ACTIVE_LOW);
            ovf_reg <= (cnt_wide > (NW+4)'(15));
          end else begin
            k_reg <= k_reg + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready   = ready;
  assign bus.busy    = !ready;
  assign bus.done    = done_reg;
  assign bus.ovf     = ovf_reg;
  assign bus.n_out   = n_reg;
  assign bus.phi_out = phi_reg;
  assign {A, B, C, D, E, F, G} = seg_reg;

endmodule

// File: tb/tb_totient_sequencer.sv
// Scoreboard bench: a N_MAX=16 active-high unit and a N_MAX=32 active-low unit share one stimulus path.
module tb_totient_sequencer;

  logic clk_0 = 1'b0;
  logic rst_n = 1'b0;
  logic drv_step = 1'b0, drv_dir = 1'b0, drv_wrap = 1'b0;
  logic sel = 1'b0;

  always #5 clk_0 = ~clk_0;

  totient_if #(.N_MAX(16)) bus16 ();
  totient_if #(.N_MAX(32)) bus32 ();

  logic a16, b16, c16, d16, e16, f16, g16;
  logic a32, b32, c32, d32, e32, f32, g32;

  assign bus16.step = drv_step & ~sel;
  assign bus16.dir  = drv_dir;
  assign bus16.wrap = drv_wrap;
  assign bus32.step = drv_step & sel;
  assign bus32.dir  = drv_dir;
  assign bus32.wrap = drv_wrap;

  totient_sequencer #(.N_MAX(16), .SEG_ACTIVE_LOW(1'b0)) dut16 (
    .clk_0(clk_0), .R(rst_n), .bus(bus16),
    .A(a16), .B(b16), .C(c16), .D(d16), .E(e16), .F(f16), .G(g16)
  );

  totient_sequencer #(.N_MAX(32), .SEG_ACTIVE_LOW(1'b1)) dut32 (
    .clk_0(clk_0), .R(rst_n), .bus(bus32),
    .A(a32), .B(b32), .C(c32), .D(d32), .E(e32), .F(f32), .G(g32)
  );

  logic [7:0] obs_n, obs_phi;
  logic [6:0] obs_seg;
  logic       obs_ready, obs_busy, obs_done, obs_ovf;

  always_comb begin
    obs_n     = sel ? 8'(bus32.n_out)   : 8'(bus16.n_out);
    obs_phi   = sel ? 8'(bus32.phi_out) : 8'(bus16.phi_out);
    obs_ready = sel ? bus32.ready : bus16.ready;
    obs_busy  = sel ? bus32.busy  : bus16.busy;
    obs_done  = sel ? bus32.done  : bus16.done;
    obs_ovf   = sel ? bus32.ovf   : bus16.ovf;
    obs_seg   = sel ? {a32, b32, c32, d32, e32, f32, g32}
                    : {a16, b16, c16, d16, e16, f16, g16};
  end

  typedef struct {
    int         n;
    int         phi;
    bit         done;
    bit         ovf;
    logic [6:0] seg;
    int         bound;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_n = 1;
  bit   m_done = 1'b0;
  int   nmax = 16;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic int gcd_ref(input int x, input int y);
    int a = x, b = y, t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  function automatic int phi_ref(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (gcd_ref(n, k) == 1) c++;
    return c;
  endfunction

  function automatic logic [6:0] seg_ref(input int v, input bit active_low);
    logic [6:0] s;
    case (v % 16)
      0: s = 7'b1111110;  1: s = 7'b0110000;  2: s = 7'b1101101;  3: s = 7'b1111001;
      4: s = 7'b0110011;  5: s = 7'b1011011;  6: s = 7'b1011111;  7: s = 7'b1110000;
      8: s = 7'b1111111;  9: s = 7'b1111011; 10: s = 7'b1110111; 11: s = 7'b0011111;
     12: s = 7'b1001110; 13: s = 7'b0111101; 14: s = 7'b1001111; default: s = 7'b1000111;
    endcase
    return active_low ? ~s : s;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_n"},     32'(obs_n), 1);
    check({tag, "_phi"},   32'(obs_phi), 1);
    check({tag, "_ready"}, 32'(obs_ready), 1);
    check({tag, "_busy"},  32'(obs_busy), 0);
    check({tag, "_done"},  32'(obs_done), 0);
    check({tag, "_ovf"},   32'(obs_ovf), 0);
    check({tag, "_seg"},   32'(obs_seg), 32'(seg_ref(1, sel)));
  endtask

  // Model the move, queue the expectation, then drive step for hold_cyc cycles and wait for ready.
  task automatic do_step(input bit d, input bit w, input int hold_cyc);
    exp_t e;
    int   tgt, lat;
    bit   moving;
    if (!d) tgt = (m_n == nmax) ? (w ? 1 : -1) : m_n + 1;
    else    tgt = (m_n == 1) ? (w ? nmax : -1) : m_n - 1;
    moving = (tgt != -1);
    if (moving) begin m_n = tgt; m_done = 1'b0; end
    else m_done = 1'b1;
    e.n = m_n; e.phi = phi_ref(m_n); e.done = m_done; e.ovf = (e.phi > 15);
    e.seg = seg_ref(e.phi, sel); e.bound = 2 + m_n * (m_n + 3);
    sb.push_back(e);

    @(negedge clk_0);
    drv_step = 1'b1; drv_dir = d; drv_wrap = w;
    for (int i = 0; i < hold_cyc; i++) @(negedge clk_0);
    drv_step = 1'b0;
    lat = hold_cyc - 1;
    if (moving) check("busy_after_accept", 32'(obs_busy), 1);
    while (!obs_ready && lat < 3000) begin
      @(negedge clk_0);
      lat++;
    end

    e = sb.pop_front();
    $display("step dut=%0d dir=%0d wrap=%0d -> n=%0d phi=%0d done=%0d ovf=%0d seg=%b lat=%0d",
             sel ? 32 : 16, d, w, obs_n, obs_phi, obs_done, obs_ovf, obs_seg, lat);
    check("latency_bound", 32'(lat <= e.bound), 1);
    check("ready", 32'(obs_ready), 1);
    check("n_out", 32'(obs_n), 32'(e.n));
    check("phi_out", 32'(obs_phi), 32'(e.phi));
    check("done", 32'(obs_done), 32'(e.done));
    check("ovf", 32'(obs_ovf), 32'(e.ovf));
    check("seg", 32'(obs_seg), 32'(e.seg));
  endtask

  initial begin
    repeat (3) @(negedge clk_0);
    sel = 1'b0; #1 check_idle("reset16");
    sel = 1'b1; #1 check_idle("reset32");
    sel = 1'b0;
    @(negedge clk_0);
    rst_n = 1'b1;

    // Up through 2..16, then one held step at the top.
    for (int i = 0; i < 15; i++) do_step(1'b0, 1'b0, 1);
    do_step(1'b0, 1'b0, 1);

    // Down with wrap all the way to 1, then wrap to 16.
    for (int i = 0; i < 15; i++) do_step(1'b1, 1'b1, 1);
    do_step(1'b1, 1'b1, 1);

    // Step held for five cycles moves by one only.
    do_step(1'b1, 1'b0, 5);
    do_step(1'b1, 1'b0, 1);
    do_step(1'b1, 1'b0, 1);

    // Reset in the middle of computing phi(12).
    @(negedge clk_0);
    drv_step = 1'b1; drv_dir = 1'b1; drv_wrap = 1'b0;
    @(negedge clk_0);
    drv_step = 1'b0;
    repeat (20) @(negedge clk_0);
    check("mid_n", 32'(obs_n), 12);
    check("mid_busy", 32'(obs_busy), 1);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk_0);
    rst_n = 1'b1;
    m_n = 1; m_done = 1'b0;
    do_step(1'b0, 1'b0, 1);

    // Wide unit: wrap down to 32, then 31, back up to 32 and hold.
    sel = 1'b1; nmax = 32; m_n = 1; m_done = 1'b0;
    #1;
    do_step(1'b1, 1'b1, 1);
    do_step(1'b1, 1'b0, 1);
    do_step(1'b0, 1'b0, 1);
    do_step(1'b0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
